packet_dispatcher_rr: RTL and testbench

Round-robin 1-to-N packet dispatcher for the router datapath. It takes one packet stream (valid/ready, multi-flit, `in_last`-delimited) and routes each whole packet to one of `NUM_PORT` output channels. It is the distribution counterpart of the base-priority input arbiter. It rotates a one-hot priority base after every packet, skips channels that are not available, and supports a forced single-target mode.

---
 rtl/packet_dispatcher_rr.sv | 145 ++++++++++++++
 tb/tb_packet_dispatcher_rr.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_dispatcher_rr.sv
// Round-robin 1-to-N packet dispatcher: routes each whole in_last-delimited packet
// to one output channel through a single registered flit stage.
module packet_dispatcher_rr #(
  parameter int NUM_PORT   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dispatch_enable,
  input  logic [NUM_PORT-1:0]   single_mask,
  input  logic [NUM_PORT-1:0]   port_avail,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [NUM_PORT-1:0]   out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic [NUM_PORT-1:0]   out_ready,
  output logic                  busy,
  output logic [NUM_PORT-1:0]   cur_port
);

  typedef enum logic [0:0] {
    IDLE_ST = 1'b0,
    LOCK_ST = 1'b1
  } state_t;

  localparam logic [NUM_PORT-1:0] ONE_HOT0 = {{(NUM_PORT-1){1'b0}}, 1'b1};

  function automatic logic [NUM_PORT-1:0] lowest_bit(input logic [NUM_PORT-1:0] v);
    return v & (~v + ONE_HOT0);
  endfunction

  // First requester at or above base, wrapping: subtract base in a doubled vector
  function automatic logic [NUM_PORT-1:0] rr_pick(input logic [NUM_PORT-1:0] req,
                                                  input logic [NUM_PORT-1:0] base);
    logic [2*NUM_PORT-1:0] dbl;
    logic [2*NUM_PORT-1:0] hit;
    dbl = {req, req};
    hit = dbl & ~(dbl - {{NUM_PORT{1'b0}}, base});
    return hit[NUM_PORT-1:0] | hit[2*NUM_PORT-1:NUM_PORT];
  endfunction

  function automatic logic [NUM_PORT-1:0] rotl1(input logic [NUM_PORT-1:0] v);
    return {v[NUM_PORT-2:0], v[NUM_PORT-1]};
  endfunction

  state_t                  state_r;
  state_t                  state_s;
  logic [NUM_PORT-1:0]     base_r;
  logic [NUM_PORT-1:0]     out_valid_r;
  logic [DATA_WIDTH-1:0]   out_data_r;
  logic                    out_last_r;
  logic [NUM_PORT-1:0]     cur_port_r;

  logic                    drain_s;
  logic                    reg_free_s;
  logic [NUM_PORT-1:0]     eligible_s;
  logic [NUM_PORT-1:0]     grant_s;
  logic [NUM_PORT-1:0]     target_s;
  logic                    in_ready_s;
  logic                    accept_s;

  assign drain_s    = |(out_valid_r & out_ready);
  assign reg_free_s = ~(|out_valid_r) | drain_s;
  assign grant_s    = rr_pick(eligible_s, base_r);
  assign accept_s   = in_valid & in_ready_s;

  // Eligibility, handshake readiness and flit target for the current state
  always_comb begin
    eligible_s = {NUM_PORT{1'b0}};
    in_ready_s = 1'b0;
    target_s   = cur_port_r;
    if (dispatch_enable) begin
      eligible_s = port_avail;
    end else begin
      eligible_s = lowest_bit(single_mask) & port_avail;
    end
    if (state_r == IDLE_ST) begin
      in_ready_s = reg_free_s & (|eligible_s);
      target_s   = grant_s;
    end else begin
      in_ready_s = reg_free_s;
      target_s   = cur_port_r;
    end
  end

  // Packet lock tracking: head without last locks, last flit unlocks
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE_ST: begin
        if (accept_s && !in_last) begin
          state_s = LOCK_ST;
        end else begin
          state_s = IDLE_ST;
        end
      end
      LOCK_ST: begin
        if (accept_s && in_last) begin
          state_s = IDLE_ST;
        end else begin
          state_s = LOCK_ST;
        end
      end
      default: state_s = IDLE_ST;
    endcase
  end

  // Output flit register, packet target and round-robin base
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE_ST;
      base_r      <= ONE_HOT0;
      out_valid_r <= {NUM_PORT{1'b0}};
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_last_r  <= 1'b0;
      cur_port_r  <= {NUM_PORT{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        out_valid_r <= target_s;
        out_data_r  <= in_data;
        out_last_r  <= in_last;
        if (state_r == IDLE_ST) begin
          cur_port_r <= grant_s;
        end
        if (in_last) begin
          base_r <= rotl1(target_s);
        end
      end else if (drain_s) begin
        out_valid_r <= {NUM_PORT{1'b0}};
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign busy      = (state_r == LOCK_ST);
  assign cur_port  = cur_port_r;

endmodule

// File: tb/tb_packet_dispatcher_rr.sv
// Bench for packet_dispatcher_rr: vector table, directed stall/reset sequences and
// randomized traffic checked against an index-based reference model.
module tb_packet_dispatcher_rr;

  localparam int N  = 4;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dispatch_enable;
  logic [N-1:0]  single_mask;
  logic [N-1:0]  port_avail;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic [N-1:0]  out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [N-1:0]  out_ready;
  logic          busy;
  logic [N-1:0]  cur_port;

  int total = 0;
  int bad   = 0;

  packet_dispatcher_rr #(.NUM_PORT(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .dispatch_enable(dispatch_enable),
    .single_mask(single_mask), .port_avail(port_avail), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .cur_port(cur_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: port indices, a scan for the grant, a one-entry output buffer
  bit            m_lock;
  bit            m_ov;
  bit            m_ol;
  int            m_base;
  int            m_cur;
  int            m_op;
  logic [DW-1:0] m_od;

  task automatic model_reset();
    m_lock = 1'b0; m_ov = 1'b0; m_ol = 1'b0;
    m_base = 0; m_cur = -1; m_op = 0; m_od = '0;
  endtask

  function automatic int m_pick();
    bit [N-1:0] el;
    int forced;
    el = '0;
    forced = -1;
    for (int j = N - 1; j >= 0; j--) if (single_mask[j]) forced = j;
    for (int j = 0; j < N; j++) begin
      if (dispatch_enable) el[j] = port_avail[j];
      else el[j] = (j == forced) && port_avail[j];
    end
    for (int k = 0; k < N; k++) if (el[(m_base + k) % N]) return (m_base + k) % N;
    return -1;
  endfunction

  function automatic bit m_ready();
    bit free;
    free = !m_ov || out_ready[m_op];
    if (m_lock) return free;
    return free && (m_pick() >= 0);
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic model_step();
    bit acc;
    bit drain;
    int p;
    acc   = in_valid && m_ready();
    drain = m_ov && out_ready[m_op];
    if (acc) begin
      p = m_lock ? m_cur : m_pick();
      m_ov = 1'b1; m_op = p; m_od = in_data; m_ol = in_last; m_cur = p;
      if (in_last) begin
        m_lock = 1'b0;
        m_base = (p + 1) % N;
      end else begin
        m_lock = 1'b1;
      end
    end else if (drain) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic cycle(input bit de, input logic [N-1:0] sm, input logic [N-1:0] av,
                       input bit iv, input bit il, input logic [DW-1:0] d,
                       input logic [N-1:0] ordy);
    @(negedge clk);
    dispatch_enable = de; single_mask = sm; port_avail = av;
    in_valid = iv; in_last = il; in_data = d; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, m_ready());
    @(posedge clk);
    model_step();
    #1;
    chk("out_valid", out_valid, m_ov ? onehot(m_op) : '0);
    chk("out_data", out_data, m_od);
    chk("out_last", out_last, m_ol);
    chk("busy", busy, m_lock);
    chk("cur_port", cur_port, onehot(m_cur));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dispatch_enable = 1'b1; single_mask = '0; port_avail = 4'b1111;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 4'b1111;
    #1;
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cur_port", cur_port, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit         de;
    logic [3:0] sm;
    logic [3:0] av;
    bit         iv;
    bit         il;
    bit         e_ir;
    logic [3:0] e_ov;
    bit         e_busy;
    logic [3:0] e_cp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit de, logic [3:0] sm, logic [3:0] av, bit iv, bit il,
                              bit e_ir, logic [3:0] e_ov, bit e_busy, logic [3:0] e_cp);
    vec_t v;
    v.de = de; v.sm = sm; v.av = av; v.iv = iv; v.il = il;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_busy = e_busy; v.e_cp = e_cp;
    return v;
  endfunction

  logic [DW-1:0] d1;
  logic [DW-1:0] d3;

  initial begin
    rst_n = 1'b0;
    dispatch_enable = 1'b1; single_mask = '0; port_avail = 4'b1111;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 4'b1111;
    model_reset();

    // Rotation over all ports, availability skip, forced target, lock and stall
    vecs.push_back(mk(1, 4'b0000, 4'b1111, 1, 1, 1, 4'b0001, 0, 4'b0001));
    vecs.push_back(mk(1, 4'b0000, 4'b1111, 1, 1, 1, 4'b0010, 0, 4'b0010));
    vecs.push_back(mk(1, 4'b0000, 4'b1111, 1, 1, 1, 4'b0100, 0, 4'b0100));
    vecs.push_back(mk(1, 4'b0000, 4'b1111, 1, 1, 1, 4'b1000, 0, 4'b1000));
    vecs.push_back(mk(1, 4'b0000, 4'b1111, 1, 1, 1, 4'b0001, 0, 4'b0001));
    vecs.push_back(mk(1, 4'b0000, 4'b1111, 0, 0, 1, 4'b0000, 0, 4'b0001));
    vecs.push_back(mk(1, 4'b0000, 4'b1000, 1, 1, 1, 4'b1000, 0, 4'b1000));
    vecs.push_back(mk(1, 4'b0000, 4'b1010, 1, 0, 1, 4'b0010, 1, 4'b0010));
    vecs.push_back(mk(1, 4'b0000, 4'b1010, 1, 0, 1, 4'b0010, 1, 4'b0010));
    vecs.push_back(mk(1, 4'b0000, 4'b1010, 1, 1, 1, 4'b0010, 0, 4'b0010));
    vecs.push_back(mk(1, 4'b0000, 4'b1010, 1, 1, 1, 4'b1000, 0, 4'b1000));
    vecs.push_back(mk(0, 4'b0110, 4'b1111, 1, 1, 1, 4'b0010, 0, 4'b0010));
    vecs.push_back(mk(0, 4'b0110, 4'b1111, 1, 1, 1, 4'b0010, 0, 4'b0010));
    vecs.push_back(mk(1, 4'b0110, 4'b1111, 1, 1, 1, 4'b0100, 0, 4'b0100));
    vecs.push_back(mk(1, 4'b0000, 4'b1111, 1, 0, 1, 4'b1000, 1, 4'b1000));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 0, 1, 4'b1000, 1, 4'b1000));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 1, 1, 4'b1000, 0, 4'b1000));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 1, 0, 4'b0000, 0, 4'b1000));
    vecs.push_back(mk(0, 4'b0001, 4'b0010, 1, 1, 0, 4'b0000, 0, 4'b1000));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 1, 1, 4'b0001, 0, 4'b0001));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      dispatch_enable = vecs[i].de; single_mask = vecs[i].sm; port_avail = vecs[i].av;
      in_valid = vecs[i].iv; in_last = vecs[i].il; in_data = DW'(i + 16);
      out_ready = 4'b1111;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_cur_port", i), cur_port, vecs[i].e_cp);
    end

    // out_ready pattern 1,0,0,1 on the target during a 4-flit packet
    do_reset();
    d1 = 64'h1111_0000_0000_0001;
    d3 = 64'h3333_0000_0000_0003;
    cycle(1, 4'b0000, 4'b1111, 1, 0, 64'h0000_0000_0000_0a00, 4'b1111);
    cycle(1, 4'b0000, 4'b1111, 1, 0, d1, 4'b0001);
    cycle(1, 4'b0000, 4'b1111, 1, 0, 64'h2222_0000_0000_0002, 4'b1110);
    chk("stall1_in_ready", in_ready, 1'b0);
    chk("stall1_out_data", out_data, d1);
    cycle(1, 4'b0000, 4'b1111, 1, 0, 64'h2222_0000_0000_0002, 4'b1110);
    chk("stall2_in_ready", in_ready, 1'b0);
    chk("stall2_out_data", out_data, d1);
    cycle(1, 4'b0000, 4'b1111, 1, 0, 64'h2222_0000_0000_0002, 4'b0001);
    cycle(1, 4'b0000, 4'b1111, 1, 1, d3, 4'b0001);
    chk("last_out_data", out_data, d3);
    chk("last_out_last", out_last, 1'b1);
    cycle(1, 4'b0000, 4'b1111, 0, 0, '0, 4'b0001);
    chk("drained_out_valid", out_valid, 4'b0000);
    chk("drained_out_data", out_data, d3);

    // Reset after the 2nd flit of a packet locked to port 1
    do_reset();
    cycle(1, 4'b0000, 4'b1111, 1, 1, 64'h55, 4'b1111);
    cycle(1, 4'b0000, 4'b1111, 1, 0, 64'h66, 4'b1111);
    cycle(1, 4'b0000, 4'b1111, 1, 0, 64'h77, 4'b1111);
    chk("pre_rst_cur_port", cur_port, 4'b0010);
    do_reset();
    cycle(1, 4'b0000, 4'b1111, 1, 1, 64'h88, 4'b1111);
    chk("post_rst_target", out_valid, 4'b0001);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            {$urandom, $urandom}, 4'(~($urandom & $urandom)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
